// File: rtl/product_accumulator.sv
// product_accumulator: sums BATCH_LEN 8-bit multiplier products into a
// saturating ACC_W-bit accumulator, then streams the sum out LSB byte first.
module product_accumulator #(
  parameter int BATCH_LEN = 4,   // products per batch, 1..255
  parameter int ACC_W     = 16   // accumulator width, multiple of 8, >= 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_product,
  input  logic       in_signed,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       overflow,
  output logic       busy
);

  localparam int NBYTES = ACC_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                 state, state_nxt;
  logic [ACC_W-1:0]       acc, acc_sum, ext;
  logic [ACC_W:0]         sum_w;
  logic [NBYTES-1:0][7:0] acc_b;
  logic [7:0]             cnt;
  logic [IDX_W-1:0]       idx;
  logic                   mode, ovf, clamp, eff_mode;
  logic                   accept, xfer, last_sample, last_byte;

  // The first sample of a batch decides the mode; later samples follow the latch.
  assign eff_mode    = (cnt == 8'd0) ? in_signed : mode;
  assign accept      = in_valid & in_ready;
  assign xfer        = ena & out_valid & out_ready;
  assign last_sample = (cnt == 8'(BATCH_LEN - 1));
  assign last_byte   = (idx == IDX_W'(NBYTES - 1));
  assign acc_b       = acc;

  // Extend the product, add one bit wider than the accumulator, clamp on overflow.
  always_comb begin
    ext      = {ACC_W{eff_mode & in_product[7]}};
    ext[7:0] = in_product;
    if (eff_mode) sum_w = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
    else          sum_w = {1'b0, acc} + {1'b0, ext};
    clamp   = eff_mode ? (sum_w[ACC_W] ^ sum_w[ACC_W-1]) : sum_w[ACC_W];
    acc_sum = sum_w[ACC_W-1:0];
    if (clamp) begin
      // Signed: the carry-out bit tells which rail was crossed.
      if (eff_mode) acc_sum = {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}};
      else          acc_sum = '1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs; in_ready is the only path from ena.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    overflow  = 1'b0;
    busy      = (cnt != 8'd0);
    case (state)
      ACCUM: begin
        in_ready = ena;
        if (ena && !clear && accept && last_sample) state_nxt = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_byte  = acc_b[idx];
        out_last  = last_byte;
        overflow  = ovf;
        if (!clear && xfer && last_byte) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end

  // Accumulator, sample count, byte index, latched mode and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc  <= '0;
      cnt  <= 8'd0;
      idx  <= '0;
      mode <= 1'b0;
      ovf  <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        acc <= acc_sum;
        ovf <= ovf | clamp;
        cnt <= cnt + 8'd1;
        if (cnt == 8'd0) mode <= in_signed;
        if (last_sample) idx <= '0;
      end
      if (xfer) begin
        if (last_byte) begin
          acc  <= '0;
          cnt  <= 8'd0;
          idx  <= '0;
          mode <= 1'b0;
          ovf  <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: main instance (BATCH_LEN=4, ACC_W=16) plus a narrow
// instance (BATCH_LEN=2, ACC_W=8) for saturation cases.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // main instance
  logic       rst_n, ena, clear, in_valid, in_signed, out_ready;
  logic [7:0] in_product;
  logic       in_ready, out_valid, out_last, overflow, busy;
  logic [7:0] out_byte;

  // saturation instance
  logic       s_ena, s_clear, s_in_valid, s_in_signed, s_out_ready;
  logic [7:0] s_in_product;
  logic       s_in_ready, s_out_valid, s_out_last, s_overflow, s_busy;
  logic [7:0] s_out_byte;

  product_accumulator #(.BATCH_LEN(4), .ACC_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .overflow(overflow), .busy(busy)
  );

  product_accumulator #(.BATCH_LEN(2), .ACC_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(s_ena), .clear(s_clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_product(s_in_product),
    .in_signed(s_in_signed), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_byte(s_out_byte), .out_last(s_out_last), .overflow(s_overflow), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [7:0] p, input logic s);
    in_valid = 1'b1; in_product = p; in_signed = s;
    tick();
  endtask

  task automatic sfeed(input logic [7:0] p, input logic s);
    s_in_valid = 1'b1; s_in_product = p; s_in_signed = s;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_product = 8'h00; out_ready = 1'b1;
    s_ena = 1'b1; s_clear = 1'b0; s_in_valid = 1'b0; s_in_signed = 1'b0;
    s_in_product = 8'h00; s_out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte",  out_byte,  0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_in_ready",  in_ready,  1);
    ena = 1'b0; #1;
    chk("rst_in_ready_ena0", in_ready, 0);
    ena = 1'b1; #1;

    // unsigned batch 4 x 225 = 900 = 0x0384
    feed(8'hE1, 0);
    chk("u_busy_after_first", busy, 1);
    feed(8'hE1, 0);
    feed(8'hE1, 0);
    chk("u_no_valid_before_last", out_valid, 0);
    feed(8'hE1, 0); in_valid = 1'b0;
    chk("u_valid_1cyc", out_valid, 1);
    chk("u_b0",         out_byte,  8'h84);
    chk("u_b0_last",    out_last,  0);
    chk("u_in_ready_emit", in_ready, 0);
    tick();
    chk("u_b1",       out_byte, 8'h03);
    chk("u_b1_last",  out_last, 1);
    chk("u_overflow", overflow, 0);
    tick();
    chk("u_done_valid", out_valid, 0);
    chk("u_done_ready", in_ready,  1);
    chk("u_done_busy",  busy,      0);

    // signed batch 4 x -56 = -224 = 0xFF20
    feed(8'hC8, 1); feed(8'hC8, 1); feed(8'hC8, 1); feed(8'hC8, 1); in_valid = 1'b0;
    chk("s_b0", out_byte, 8'h20);
    tick();
    chk("s_b1",      out_byte, 8'hFF);
    chk("s_b1_last", out_last, 1);
    chk("s_ovf",     overflow, 0);
    tick();

    // same with in_signed toggling after the first sample
    feed(8'hC8, 1); feed(8'hC8, 0); feed(8'hC8, 1); feed(8'hC8, 0); in_valid = 1'b0;
    chk("t_b0", out_byte, 8'h20);
    tick();
    chk("t_b1", out_byte, 8'hFF);
    tick();

    // backpressure
    out_ready = 1'b0;
    feed(8'hE1, 0); feed(8'hE1, 0); feed(8'hE1, 0); feed(8'hE1, 0); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_byte",  out_byte,  8'h84);
      chk("bp_ready", in_ready,  0);
    end
    out_ready = 1'b1; #1;
    chk("bp_b0", out_byte, 8'h84);
    tick();
    chk("bp_b1",      out_byte, 8'h03);
    chk("bp_b1_last", out_last, 1);
    tick();
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_valid_after",    out_valid, 0);

    // clear mid-batch, then ena low mid-batch
    feed(8'd5, 0); feed(8'd7, 0); in_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_busy", busy, 0);
    feed(8'd1, 0); feed(8'd1, 0);
    ena = 1'b0; in_valid = 1'b1; #1;
    chk("ena0_in_ready", in_ready, 0);
    tick(); tick();
    chk("ena0_busy",  busy,      1);
    chk("ena0_valid", out_valid, 0);
    ena = 1'b1;
    feed(8'd1, 0);
    chk("ena_cnt_kept", out_valid, 0);
    feed(8'd1, 0); in_valid = 1'b0;
    chk("clr_b0", out_byte, 8'h04);
    tick();
    chk("clr_b1", out_byte, 8'h00);
    tick();

    // reset mid-emit
    feed(8'd1, 0); feed(8'd1, 0); feed(8'd1, 0); feed(8'd1, 0); in_valid = 1'b0;
    chk("rme_b0", out_byte, 8'h04);
    tick();
    out_ready = 1'b0;
    chk("rme_b1_last", out_last, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rme_valid",    out_valid, 0);
    chk("rme_busy",     busy,      0);
    chk("rme_overflow", overflow,  0);
    out_ready = 1'b1;
    feed(8'd1, 0); feed(8'd1, 0); feed(8'd1, 0); feed(8'd1, 0); in_valid = 1'b0;
    chk("rme2_b0", out_byte, 8'h04);
    tick();
    chk("rme2_b1", out_byte, 8'h00);
    tick();

    // saturation, ACC_W=8, BATCH_LEN=2
    sfeed(8'hE1, 0); sfeed(8'hE1, 0); s_in_valid = 1'b0;
    chk("sat_u_byte", s_out_byte,  8'hFF);
    chk("sat_u_ovf",  s_overflow,  1);
    chk("sat_u_last", s_out_last,  1);
    tick();
    chk("sat_u_done", s_out_valid, 0);
    sfeed(8'h40, 1); sfeed(8'h40, 1); s_in_valid = 1'b0;
    chk("sat_sp_byte", s_out_byte, 8'h7F);
    chk("sat_sp_ovf",  s_overflow, 1);
    tick();
    sfeed(8'h80, 1); sfeed(8'h80, 1); s_in_valid = 1'b0;
    chk("sat_sn_byte", s_out_byte, 8'h80);
    chk("sat_sn_ovf",  s_overflow, 1);
    tick();
    sfeed(8'h01, 0); sfeed(8'h01, 0); s_in_valid = 1'b0;
    chk("sat_n_byte", s_out_byte, 8'h02);
    chk("sat_n_ovf",  s_overflow, 0);
    tick();
    chk("sat_n_done", s_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 signed/unsigned multiplier's 8-bit product.
- Accepts products over a valid/ready handshake and sums a batch of BATCH_LEN products into a saturating accumulator.
- When the batch is complete, emits the sum byte-serially, LSB first, on an 8-bit output handshake that fits the top-level's 8-bit dedicated outputs.

Parameters:
- BATCH_LEN, 4, number of products summed per batch (1..255).
- ACC_W, 16, accumulator width in bits; must be a multiple of 8 and at least 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ena  input  1  design enable; low freezes all state.
- clear  input  1  synchronous batch abort.
- in_valid  input  1  in_product is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  8  multiplier product.
- in_signed  input  1  signed_mode that produced in_product.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  consumer accepts out_byte.
- out_byte  output  8  current result byte.
- out_last  output  1  out_byte is the most-significant (final) byte.
- overflow  output  1  batch saturated; valid while out_valid is high.
- busy  output  1  a batch is in progress or the result is being emitted.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to ACCUM; accumulator, sample count, byte index, latched mode and overflow all go to 0.
  - Outputs after reset: out_valid=0, out_byte=0, out_last=0, overflow=0, busy=0, in_ready=ena.
- Priority: reset > clear > ena low > normal operation.
- clear (while ena=1): same clearing effect as reset; takes effect in any state, including mid-emit. Any pending byte is dropped.
- ena low: no accepts; in_ready=0; no state, counter or output change. out_valid holds its value, but no byte transfers until ena is high again.
- State ACCUM:
  - in_ready=1 when ena=1.
  - Accept = in_valid & in_ready.
  - On the first accept of a batch, latch in_signed as the batch mode. Later samples in the same batch use the latched mode; their in_signed is ignored.
  - Extension to ACC_W: sign-extend in signed mode, zero-extend in unsigned mode.
  - Add at ACC_W+1 bits, then saturate:
    - signed mode: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    - unsigned mode: clamp to 2^ACC_W-1.
  - Any clamp sets the sticky overflow flag for the batch.
  - busy=1 once count>0.
  - When the accept brings count to BATCH_LEN, go to EMIT on the next cycle, with byte index 0.
- State EMIT:
  - in_ready=0; busy=1; out_valid=1.
  - out_byte = accumulator byte[index]; out_last = (index == ACC_W/8-1).
  - out_byte, out_last and overflow are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready:
    - If not the last byte: index increments.
    - If the last byte: accumulator, count and overflow clear, and the state returns to ACCUM. The first cycle after this has in_ready=1 and out_valid=0.
- Latency: the first result byte appears 1 cycle after the accept of the final sample.
- Throughput:
  - One product per cycle during ACCUM.
  - One byte per cycle during EMIT with out_ready held high.
- BATCH_LEN=1: every accepted product goes straight to EMIT.
- Combinational paths: no in->out path except in_ready, which depends on ena. out_valid is registered or state-decoded.

Test Plan:
- Unsigned batch, BATCH_LEN=4, ACC_W=16:
  - Stimulus: in_signed=0, in_product=0xE1 (225) x4, back-to-back.
  - Required: out_byte=0x84 then 0x03, out_last on 0x03, overflow=0; first byte 1 cycle after the 4th accept.
- Signed batch:
  - Stimulus: in_signed=1, in_product=0xC8 (-56) x4.
  - Required: sum -224 → bytes 0x20 then 0xFF, overflow=0.
  - Repeat with in_signed toggling after the first sample; the result must be identical (mode latched).
- Backpressure:
  - Stimulus: during EMIT, out_ready=0 for 3 cycles.
  - Required: out_valid=1, out_byte=0x84 held, in_ready=0. After out_ready=1, bytes 0x84 then 0x03; in_ready=1 the cycle after the last transfer.
- Saturation, ACC_W=8, BATCH_LEN=2:
  - Unsigned 225+225 → out_byte=0xFF, overflow=1, out_last=1.
  - Signed 0x40+0x40 (64+64) → 0x7F, overflow=1.
  - Next batch 0x01+0x01 → 0x02, overflow=0.
- Clear and ena:
  - Stimulus: accept 2 products (5, 7), pulse clear, then accept 4 products of 1.
  - Required: result 0x0004.
  - With ena=0 for 2 cycles mid-batch while in_valid=1: no samples are accepted and the count is unchanged.
- Reset mid-emit:
  - Stimulus: assert rst_n=0 for 1 cycle after the first byte has transferred.
  - Required: next cycle out_valid=0, busy=0, overflow=0; a fresh batch of 4x0x01 yields 0x04, 0x00.
